// File: rtl/vpu_dst_port.sv
// ============================================================================
// vpu_dst_port : captures ALU results into a small FIFO and drains them to
// the SRAM write port at auto-incrementing addresses. Option: VPU_DST_PARITY_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module vpu_dst_port #(
  parameter int OPCODE_WIDTH = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int CNT_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
  input  logic [CNT_WIDTH-1:0]    elem_cnt_i,
  input  logic [OPCODE_WIDTH-1:0] result_i,
  input  logic                    done_i,
  input  logic                    wr_ready_i,
  output logic                    wr_en_o,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [OPCODE_WIDTH-1:0] wr_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    ovf_err_o
`ifdef VPU_DST_PARITY_EN
  ,
  output logic                    wr_par_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef VPU_DST_PARITY_EN
  localparam int ENTRY_W = OPCODE_WIDTH + 1;
`else
  localparam int ENTRY_W = OPCODE_WIDTH;
`endif
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  remain_q, remain_d;
  logic [CNT_WIDTH-1:0]  quota_q, quota_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        occ_q, occ_d;
  logic                  ovf_q, ovf_d;

  logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head;
  logic                  run, fifo_empty, fifo_full, want_push, push, pop, drop;

`ifdef VPU_DST_PARITY_EN
  assign push_entry = {^result_i, result_i};
  assign wr_par_o   = wr_en_o ? head[OPCODE_WIDTH] : 1'b0;
`else
  assign push_entry = result_i;
`endif

  assign head       = mem_q[rd_ptr_q];
  assign run        = (state_q == S_RUN);
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == FULL_OCC);

  assign wr_en_o    = run && !fifo_empty;
  assign wr_addr_o  = addr_q;
  assign wr_data_o  = wr_en_o ? head[OPCODE_WIDTH-1:0] : '0;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_FLUSH);
  assign ovf_err_o  = ovf_q;

  // Results beyond the programmed count never reach the FIFO; a pop in the
  // same cycle frees the slot, so a full FIFO can still accept.
  assign pop       = wr_en_o && wr_ready_i;
  assign want_push = run && done_i && (quota_q != '0);
  assign push      = want_push && (!fifo_full || pop);
  assign drop      = want_push && fifo_full && !pop;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    quota_d  = quota_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      occ_d = occ_q + (PTR_W+1)'(1);
    else if (pop && !push) occ_d = occ_q - (PTR_W+1)'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d   = dst_addr_i;
          remain_d = elem_cnt_i;
          quota_d  = elem_cnt_i;
          ovf_d    = 1'b0;
          state_d  = (elem_cnt_i == '0) ? S_FLUSH : S_RUN;
        end
      end
      S_RUN: begin
        if (push) quota_d = quota_q - CNT_WIDTH'(1);
        if (drop) ovf_d = 1'b1;
        if (pop) begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          remain_d = remain_q - CNT_WIDTH'(1);
          if (remain_q == CNT_WIDTH'(1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      quota_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      quota_q  <= quota_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: the output mux hides entries while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

`default_nettype wire

// File: tb/tb_vpu_dst_port.sv
// ============================================================================
// tb_vpu_dst_port : table vectors, directed corner sequences and randomized
// traffic against a queue-based reference model. Option: VPU_DST_PARITY_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vpu_dst_port;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        start_i, done_i, wr_ready_i;
  logic [9:0]  dst_addr_i;
  logic [7:0]  elem_cnt_i;
  logic [31:0] result_i;
  logic        wr_en_o, busy_o, done_o, ovf_err_o;
  logic [9:0]  wr_addr_o;
  logic [31:0] wr_data_o;
`ifdef VPU_DST_PARITY_EN
  logic        wr_par_o;
`endif

  vpu_dst_port #(
    .OPCODE_WIDTH(32), .ADDR_WIDTH(10), .CNT_WIDTH(8), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .dst_addr_i(dst_addr_i),
    .elem_cnt_i(elem_cnt_i), .result_i(result_i), .done_i(done_i),
    .wr_ready_i(wr_ready_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o),
    .ovf_err_o(ovf_err_o)
`ifdef VPU_DST_PARITY_EN
    , .wr_par_o(wr_par_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a transfer is a base address, a target count, a count of
  // accepted results and a queue of results awaiting their write.
  int          m_mode;       // 0 idle, 1 collecting/writing, 2 completion cycle
  logic [9:0]  m_base;
  int          m_total, m_accepted, m_written;
  logic        m_ovf;
  logic [31:0] m_q[$];

  logic [9:0]  log_a[$];
  logic [31:0] log_d[$];

  task automatic model_reset();
    m_mode = 0; m_base = '0; m_total = 0; m_accepted = 0; m_written = 0;
    m_ovf = 1'b0; m_q.delete();
  endtask

  task automatic model_check();
    logic        e_en;
    logic [9:0]  e_addr;
    logic [31:0] e_data;
    e_en   = (m_mode == 1) && (m_q.size() > 0);
    e_addr = m_base + 10'(m_written);
    e_data = e_en ? m_q[0] : 32'h0;
    check("m_wr_en", 64'(wr_en_o), 64'(e_en));
    check("m_wr_addr", 64'(wr_addr_o), 64'(e_addr));
    check("m_wr_data", 64'(wr_data_o), 64'(e_data));
    check("m_busy", 64'(busy_o), 64'(m_mode != 0));
    check("m_done", 64'(done_o), 64'(m_mode == 2));
    check("m_ovf", 64'(ovf_err_o), 64'(m_ovf));
`ifdef VPU_DST_PARITY_EN
    check("m_par", 64'(wr_par_o), 64'(e_en ? ^e_data : 1'b0));
`endif
  endtask

  task automatic model_step(input logic st, input logic [9:0] a, input logic [7:0] c,
                            input logic dn, input logic [31:0] r, input logic rdy);
    int  sz;
    bit  pop;
    case (m_mode)
      0: if (st) begin
        m_base = a; m_total = int'(c); m_accepted = 0; m_written = 0;
        m_ovf = 1'b0; m_q.delete();
        m_mode = (c == 0) ? 2 : 1;
      end
      1: begin
        sz  = m_q.size();
        pop = (sz > 0) && rdy;
        if (dn && m_accepted < m_total) begin
          if (sz < DEPTH || pop) begin
            m_q.push_back(r);
            m_accepted++;
          end else m_ovf = 1'b1;
        end
        if (pop) begin
          void'(m_q.pop_front());
          m_written++;
          if (m_written == m_total) m_mode = 2;
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  // One clock: apply inputs, check the current cycle, log writes, advance.
  task automatic cycle(input logic st, input logic [9:0] a, input logic [7:0] c,
                       input logic dn, input logic [31:0] r, input logic rdy);
    start_i = st; dst_addr_i = a; elem_cnt_i = c; done_i = dn; result_i = r;
    wr_ready_i = rdy;
    model_check();
    if (wr_en_o && wr_ready_i) begin
      log_a.push_back(wr_addr_o);
      log_d.push_back(wr_data_o);
    end
    @(posedge clk);
    model_step(st, a, c, dn, r, rdy);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 10'h0, 8'h0, 1'b0, 32'h0, rdy);
  endtask

  typedef struct {
    logic        st;
    logic [9:0]  a;
    logic [7:0]  c;
    logic        dn;
    logic [31:0] r;
    logic        rdy;
    logic        e_en;
    logic [9:0]  e_addr;
    logic [31:0] e_data;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 10'h010, 8'd3, 1'b0, 32'h00, 1'b1, 1'b0, 10'h000, 32'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 10'h000, 8'd0, 1'b1, 32'h11, 1'b1, 1'b0, 10'h010, 32'h00, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 10'h000, 8'd0, 1'b1, 32'h22, 1'b1, 1'b1, 10'h010, 32'h11, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 10'h000, 8'd0, 1'b1, 32'h33, 1'b1, 1'b1, 10'h011, 32'h22, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 10'h000, 8'd0, 1'b0, 32'h00, 1'b1, 1'b1, 10'h012, 32'h33, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 10'h000, 8'd0, 1'b0, 32'h00, 1'b1, 1'b0, 10'h013, 32'h00, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 10'h000, 8'd0, 1'b0, 32'h00, 1'b1, 1'b0, 10'h013, 32'h00, 1'b0, 1'b0};

    rst = 1'b1; start_i = 1'b0; done_i = 1'b0; wr_ready_i = 1'b0;
    dst_addr_i = '0; elem_cnt_i = '0; result_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic transfer from the table.
    for (int i = 0; i < 7; i++) begin
      check($sformatf("tbl%0d_en", i), 64'(wr_en_o), 64'(tbl[i].e_en));
      check($sformatf("tbl%0d_addr", i), 64'(wr_addr_o), 64'(tbl[i].e_addr));
      check($sformatf("tbl%0d_data", i), 64'(wr_data_o), 64'(tbl[i].e_data));
      check($sformatf("tbl%0d_busy", i), 64'(busy_o), 64'(tbl[i].e_busy));
      check($sformatf("tbl%0d_done", i), 64'(done_o), 64'(tbl[i].e_done));
      cycle(tbl[i].st, tbl[i].a, tbl[i].c, tbl[i].dn, tbl[i].r, tbl[i].rdy);
    end

    // Backpressure: head word must hold while the port stalls.
    log_a.delete(); log_d.delete();
    cycle(1'b1, 10'h100, 8'd2, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 10'h0, 8'd0, 1'b1, 32'hA1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_en_hold", 64'(wr_en_o), 64'd1);
      check("bp_addr_hold", 64'(wr_addr_o), 64'h100);
      check("bp_data_hold", 64'(wr_data_o), 64'hA1);
      cycle(1'b0, 10'h0, 8'd0, (i == 0), 32'hB2, 1'b0);
    end
    repeat (4) idle(1'b1);
    check("bp_nwrites", 64'(log_a.size()), 64'd2);
    if (log_a.size() == 2) begin
      check("bp_w0", {22'h0, log_a[0], log_d[0]}, {22'h0, 10'h100, 32'hA1});
      check("bp_w1", {22'h0, log_a[1], log_d[1]}, {22'h0, 10'h101, 32'hB2});
    end

    // Overflow: fifth result into a full, stalled FIFO is dropped.
    log_a.delete(); log_d.delete();
    cycle(1'b1, 10'h020, 8'd5, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 5; i++) cycle(1'b0, 10'h0, 8'd0, 1'b1, 32'(i), 1'b0);
    check("ovf_set", 64'(ovf_err_o), 64'd1);
    repeat (4) idle(1'b1);
    cycle(1'b0, 10'h0, 8'd0, 1'b1, 32'h66, 1'b1);
    begin
      int k = 0;
      while (busy_o && k < 10) begin idle(1'b1); k++; end
      check("ovf_drain_timeout", 64'(busy_o), 64'd0);
    end
    check("ovf_sticky", 64'(ovf_err_o), 64'd1);
    check("ovf_nwrites", 64'(log_d.size()), 64'd5);
    if (log_d.size() == 5) begin
      check("ovf_w3", 64'(log_d[3]), 64'h4);
      check("ovf_w4_not5", 64'(log_d[4]), 64'h66);
      check("ovf_w4_addr", 64'(log_a[4]), 64'h024);
    end

    // Address wrap, then a zero-length transfer.
    log_a.delete(); log_d.delete();
    cycle(1'b1, 10'h3FE, 8'd3, 1'b0, 32'h0, 1'b1);
    check("ovf_cleared", 64'(ovf_err_o), 64'd0);
    cycle(1'b0, 10'h0, 8'd0, 1'b1, 32'h0A, 1'b1);
    cycle(1'b0, 10'h0, 8'd0, 1'b1, 32'h0B, 1'b1);
    cycle(1'b0, 10'h0, 8'd0, 1'b1, 32'h0C, 1'b1);
    repeat (3) idle(1'b1);
    check("wrap_nwrites", 64'(log_a.size()), 64'd3);
    if (log_a.size() == 3) begin
      check("wrap_a0", 64'(log_a[0]), 64'h3FE);
      check("wrap_a1", 64'(log_a[1]), 64'h3FF);
      check("wrap_a2", 64'(log_a[2]), 64'h000);
    end
    cycle(1'b1, 10'h055, 8'd0, 1'b0, 32'h0, 1'b1);
    check("zero_done", 64'(done_o), 64'd1);
    check("zero_busy", 64'(busy_o), 64'd1);
    idle(1'b1);
    check("zero_done_end", 64'(done_o), 64'd0);
    check("zero_busy_end", 64'(busy_o), 64'd0);
    check("zero_nwrites", 64'(log_a.size()), 64'd3);

    // Asynchronous reset after one of three writes.
    log_a.delete(); log_d.delete();
    cycle(1'b1, 10'h040, 8'd3, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 10'h0, 8'd0, 1'b1, 32'h5, 1'b1);
    cycle(1'b0, 10'h0, 8'd0, 1'b1, 32'h6, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_en", 64'(wr_en_o), 64'd0);
    check("rst_addr", 64'(wr_addr_o), 64'd0);
    check("rst_data", 64'(wr_data_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    log_a.delete(); log_d.delete();
    cycle(1'b1, 10'h050, 8'd1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 10'h0, 8'd0, 1'b1, 32'h77, 1'b1);
    repeat (3) idle(1'b1);
    check("post_rst_nwrites", 64'(log_a.size()), 64'd1);
    if (log_a.size() == 1)
      check("post_rst_w0", {22'h0, log_a[0], log_d[0]}, {22'h0, 10'h050, 32'h77});

`ifdef VPU_DST_PARITY_EN
    cycle(1'b1, 10'h000, 8'd2, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 10'h0, 8'd0, 1'b1, 32'h1, 1'b1);
    check("par_one", 64'(wr_par_o), 64'd1);
    cycle(1'b0, 10'h0, 8'd0, 1'b1, 32'h3, 1'b1);
    check("par_three", 64'(wr_par_o), 64'd0);
    repeat (3) idle(1'b1);
`endif

    // Randomized traffic, including ignored starts and surplus results.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 7) == 0), 10'($urandom), 8'($urandom_range(0, 6)),
            ($urandom_range(0, 1) == 1), $urandom, ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
